rcc_sdram_clk_ctrl: RTL and testbench
=====================================

// Module: rcc_sdram_clk_ctrl
// PURPOSE
//  Sequencer in the RCC domain that drives the SDRAM clock divider and the SDRAM-domain reset.
//  - Generates a clock-enable pulse stream clk_sdram_en_o at clk_i/(div+1).
//  - Runs a request/ready handshake for divider changes; each change runs this sequence:
//    gate the enables -> switch the divider -> wait for sync -> hold the SDRAM reset -> resume.
//  - Sits directly upstream of the SDRAM controller, which consumes clk_sdram_en_o and sdram_rst_o.
// PARAMETERS
//  DIV_W      4  width of the divider value
//  DIV_RESET  1  divider value loaded on reset (1 -> one enable every 2 clk_i cycles)
//  MUX_DELAY  2  gate cycles before the divider switch (>=1)
//  SYNC_DELAY 2  settle cycles after the divider switch (>=1)
//  RST_HOLD   8  cycles sdram_rst_o stays high after settling, and after rst_i release (>=1)
// PORTS
//  clk_i          in   1      single system clock
//  rst_i          in   1      synchronous, active-high reset
//  req_valid_i    in   1      divider change request
//  req_div_i      in   DIV_W  requested divider; sampled only on acceptance
//  req_ready_o    out  1      high only in IDLE; acceptance = req_valid_i & req_ready_o
//  clk_sdram_en_o out  1      1-cycle enable pulse for the SDRAM domain
//  sdram_rst_o    out  1      SDRAM-domain reset, active high
//  div_o          out  DIV_W  divider currently in force
//  busy_o         out  1      high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst_i=1, any state), taking effect at the next edge:
//   - FSM=RST, hold counter=RST_HOLD, cnt=0, div_o=DIV_RESET.
//   - Outputs: sdram_rst_o=1, req_ready_o=0, busy_o=1, clk_sdram_en_o=0.
//   - Any pending change is discarded.
//  Divider counter cnt[DIV_W-1:0]:
//   - Forced to 0 in GATE/SWITCH/SYNC; counts in RST and IDLE.
//   - clk_sdram_en_o=1 when cnt==div_o, and cnt then wraps to 0.
//   - div_o=0 -> enable every cycle.
//   - Enable is never asserted in GATE/SWITCH/SYNC.
//  FSM (accept at cycle T; d=DIV_W-bit div):
//   - IDLE: req_ready_o=1. On accept:
//     - req_div_i==div_o: fast path. Stay IDLE, no gap in enables, sdram_rst_o stays 0.
//     - Otherwise: latch req_div_i and go to GATE.
//   - GATE: MUX_DELAY cycles (T+1..T+MUX_DELAY), enables off.
//   - SWITCH: 1 cycle. sdram_rst_o=1. div_o <= latched value (visible next cycle).
//   - SYNC: SYNC_DELAY cycles, sdram_rst_o=1.
//   - RST: RST_HOLD cycles. sdram_rst_o=1, cnt runs from 0, enables resume at the new rate.
//   - RST -> IDLE: sdram_rst_o=0 and req_ready_o=1 in the same cycle.
//  Timing and handshake:
//   - Busy length = MUX_DELAY+1+SYNC_DELAY+RST_HOLD cycles (13 with defaults).
//   - Requests held during busy wait (no drop, no queue).
//   - req_div_i changes while not accepted are ignored.
//  Mid-sequence:
//   - rst_i overrides every state in the same edge.
//   - No other input aborts a sequence in progress.
// TESTING
//  1 Reset: rst_i=1 for 3 cycles, release at cycle 0.
//    -> sdram_rst_o=1 for cycles 0..7; enables at 1,3,5,7,...; req_ready_o=1 and sdram_rst_o=0 at cycle 8.
//  2 Change 1->3, accepted at T:
//    -> enables off T+1..T+5; sdram_rst_o=1 T+3..T+13; div_o=3 from T+4.
//    -> enables at T+9, T+13, T+17; req_ready_o=1 at T+14.
//  3 Same-value request: div_o=3, req div 3.
//    -> accepted in 1 cycle, req_ready_o stays 1, enable period unchanged, sdram_rst_o=0.
//  4 Back-to-back: req_valid_i held during busy, req_div_i changes 5->7 mid-sequence.
//    -> second accept at T+14 uses 7; exactly one sequence per accept.
//  5 rst_i pulsed at T+4 of a 1->3 change.
//    -> next cycle div_o=1, FSM=RST; reset sequence of test 1 follows.
//  6 Change to div 0: after settle, clk_sdram_en_o=1 every cycle from the first RST cycle.

Source files
------------

// File: rtl/rcc_sdram_clk_ctrl.sv
// rcc_sdram_clk_ctrl
// RCC-domain sequencer for the SDRAM clock divider and the SDRAM-domain reset.
// Produces a clk_i/(div+1) enable pulse stream and runs divider changes via a
// valid/ready handshake: gate -> switch -> sync -> hold reset -> resume.
module rcc_sdram_clk_ctrl #(
  parameter int DIV_W      = 4,
  parameter int DIV_RESET  = 1,
  parameter int MUX_DELAY  = 2,
  parameter int SYNC_DELAY = 2,
  parameter int RST_HOLD   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  input  logic [DIV_W-1:0] req_div_i,
  output logic             req_ready_o,
  output logic             clk_sdram_en_o,
  output logic             sdram_rst_o,
  output logic [DIV_W-1:0] div_o,
  output logic             busy_o
);

  // One down-counter is shared by the GATE, SYNC and RST phases, so it must
  // be wide enough for the longest of the three delays.
  localparam int TMR_MAX_GS = (MUX_DELAY > SYNC_DELAY) ? MUX_DELAY : SYNC_DELAY;
  localparam int TMR_MAX    = (TMR_MAX_GS > RST_HOLD) ? TMR_MAX_GS : RST_HOLD;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_MUX  = TMR_W'(MUX_DELAY);
  localparam logic [TMR_W-1:0] TMR_SYNC = TMR_W'(SYNC_DELAY);
  localparam logic [TMR_W-1:0] TMR_HOLD = TMR_W'(RST_HOLD);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_RESET);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_IDLE   = 3'd1,
    S_GATE   = 3'd2,
    S_SWITCH = 3'd3,
    S_SYNC   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q,   tmr_d;
  logic [DIV_W-1:0] cnt_q,   cnt_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [DIV_W-1:0] pend_q,  pend_d;

  logic accept;
  logic tmr_last;
  logic cnt_run;
  logic cnt_hit;

  assign accept   = req_valid_i && (state_q == S_IDLE);
  assign tmr_last = (tmr_q == TMR_ONE);

  // Sequencer: next state, phase timer and divider/pending-divider updates.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    div_d   = div_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_RST: begin
        if (tmr_last) state_d = S_IDLE;
        else          tmr_d   = tmr_q - TMR_ONE;
      end
      S_IDLE: begin
        // A request for the divider already in force is absorbed here with
        // no gap in the enables and no reset pulse.
        if (accept && (req_div_i != div_q)) begin
          pend_d  = req_div_i;
          tmr_d   = TMR_MUX;
          state_d = S_GATE;
        end
      end
      S_GATE: begin
        if (tmr_last) state_d = S_SWITCH;
        else          tmr_d   = tmr_q - TMR_ONE;
      end
      S_SWITCH: begin
        div_d   = pend_q;
        tmr_d   = TMR_SYNC;
        state_d = S_SYNC;
      end
      S_SYNC: begin
        if (tmr_last) begin
          tmr_d   = TMR_HOLD;
          state_d = S_RST;
        end else begin
          tmr_d   = tmr_q - TMR_ONE;
        end
      end
      default: begin
        tmr_d   = TMR_HOLD;
        state_d = S_RST;
      end
    endcase
  end

  // Enable divider: counts only while the SDRAM domain is clocked (RST/IDLE),
  // held at zero while gated so the new rate starts from a clean phase.
  always_comb begin
    cnt_run = (state_q == S_IDLE) || (state_q == S_RST);
    cnt_hit = cnt_run && (cnt_q == div_q);
    cnt_d   = '0;
    if (cnt_run && (cnt_q < div_q)) cnt_d = cnt_q + 1'b1;
  end

  // State registers; rst_i overrides any phase and drops a pending change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RST;
      tmr_q   <= TMR_HOLD;
      cnt_q   <= '0;
      div_q   <= DIV_RST;
      pend_q  <= DIV_RST;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
    end
  end

  assign req_ready_o    = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign sdram_rst_o    = (state_q == S_RST) || (state_q == S_SWITCH) || (state_q == S_SYNC);
  assign clk_sdram_en_o = cnt_hit;
  assign div_o          = div_q;

endmodule

// File: tb/tb_rcc_sdram_clk_ctrl.sv
// Bench for rcc_sdram_clk_ctrl: timeline model (cycles since reset/accept)
// checked every cycle, directed scenarios with literal expectations, then
// randomized traffic.
module tb_rcc_sdram_clk_ctrl;
  localparam int DIV_W = 4, DIV_RESET = 1, MUX = 2, SYNC = 2, HOLD = 8;
  localparam int BUSY = MUX + 1 + SYNC + HOLD;
  localparam int TRN = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rv = 1'b0;
  logic [DIV_W-1:0] rd = '0;
  logic ready, en, srst, busy;
  logic [DIV_W-1:0] div;

  always #5 clk = ~clk;

  rcc_sdram_clk_ctrl #(
    .DIV_W(DIV_W), .DIV_RESET(DIV_RESET), .MUX_DELAY(MUX),
    .SYNC_DELAY(SYNC), .RST_HOLD(HOLD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_div_i(rd),
    .req_ready_o(ready), .clk_sdram_en_o(en), .sdram_rst_o(srst),
    .div_o(div), .busy_o(busy)
  );

  int errs = 0, checks = 0, cyc = 0;
  bit model_on = 0;

  // Model: anchors in time rather than states.
  int rst_start = -1000;   // first cycle of the reset hold window
  int seq_start = -1;      // accept cycle of the change in flight, -1 if none
  int origin = 0;          // cycle where the enable phase counter was zero
  logic [DIV_W-1:0] m_div = DIV_W'(DIV_RESET);
  logic [DIV_W-1:0] seq_div = '0;

  logic tr_en[TRN], tr_rst[TRN], tr_rdy[TRN];
  logic [DIV_W-1:0] tr_div[TRN];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit phase_hit(int c, int o, logic [DIV_W-1:0] d);
    int dd;
    dd = int'(d);
    return ((c - o) % (dd + 1)) == dd;
  endfunction

  function automatic void expect_now(int c, output bit e_rdy, output bit e_busy,
                                     output bit e_rst, output bit e_en,
                                     output logic [DIV_W-1:0] e_div);
    int k;
    e_div = m_div;
    if (c - rst_start < HOLD) begin
      e_rdy = 0; e_busy = 1; e_rst = 1;
      e_en = phase_hit(c, origin, m_div);
    end else if (seq_start >= 0) begin
      k = c - seq_start;
      e_rdy = 0; e_busy = 1;
      if (k >= MUX + 2) e_div = seq_div;
      e_rst = (k >= MUX + 1);
      e_en = (k >= MUX + SYNC + 2) ? phase_hit(c, origin, seq_div) : 1'b0;
    end else begin
      e_rdy = 1; e_busy = 0; e_rst = 0;
      e_en = phase_hit(c, origin, m_div);
    end
  endfunction

  // Compare + model advance, once per cycle on the falling edge.
  always @(negedge clk) begin
    bit e_rdy, e_busy, e_rst, e_en;
    logic [DIV_W-1:0] e_div;
    e_rdy = 0; e_busy = 0; e_rst = 0; e_en = 0; e_div = '0;
    if (model_on) begin
      expect_now(cyc, e_rdy, e_busy, e_rst, e_en, e_div);
      chk("ready", 32'(ready), 32'(e_rdy));
      chk("busy",  32'(busy),  32'(e_busy));
      chk("sdram_rst", 32'(srst), 32'(e_rst));
      chk("en",    32'(en),    32'(e_en));
      chk("div",   32'(div),   32'(e_div));
    end
    if (cyc < TRN) begin
      tr_en[cyc] = en; tr_rst[cyc] = srst; tr_rdy[cyc] = ready; tr_div[cyc] = div;
    end
    if (rst) begin
      rst_start = cyc + 1; origin = cyc + 1; seq_start = -1;
      m_div = DIV_W'(DIV_RESET); model_on = 1;
    end else if (model_on) begin
      if (seq_start >= 0 && cyc + 1 - seq_start > BUSY) begin
        m_div = seq_div; seq_start = -1;
      end
      if (e_rdy && rv && rd != m_div) begin
        seq_start = cyc; seq_div = rd; origin = cyc + MUX + SYNC + 2;
      end
    end
    cyc++;
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int b;
    b = 0;
    while (!ready && b < 60) begin step(1); b++; end
    if (!ready) begin
      checks++; errs++;
      $display("FAIL wait_ready timeout cyc=%0d got=0 exp=1", cyc);
    end
  endtask

  initial begin
    int t;
    // 1: reset held 3 cycles, released at cycle R
    step(3);
    rst = 0;
    t = cyc;
    step(12);
    for (int k = 0; k < 8; k++) chk("t1_rst_hold", 32'(tr_rst[t+k]), 32'd1);
    chk("t1_rst_end", 32'(tr_rst[t+8]), 32'd0);
    chk("t1_rdy7", 32'(tr_rdy[t+7]), 32'd0);
    chk("t1_rdy8", 32'(tr_rdy[t+8]), 32'd1);
    chk("t1_en0", 32'(tr_en[t]), 32'd0);
    chk("t1_en1", 32'(tr_en[t+1]), 32'd1);
    chk("t1_en2", 32'(tr_en[t+2]), 32'd0);
    chk("t1_en7", 32'(tr_en[t+7]), 32'd1);

    // 2: change 1 -> 3
    wait_ready();
    t = cyc; rv = 1; rd = 4'd3;
    step(1); rv = 0;
    step(20);
    for (int k = 1; k <= 5; k++) chk("t2_gap", 32'(tr_en[t+k]), 32'd0);
    chk("t2_rst2", 32'(tr_rst[t+2]), 32'd0);
    chk("t2_rst3", 32'(tr_rst[t+3]), 32'd1);
    chk("t2_rst13", 32'(tr_rst[t+13]), 32'd1);
    chk("t2_rst14", 32'(tr_rst[t+14]), 32'd0);
    chk("t2_div3", 32'(tr_div[t+3]), 32'd1);
    chk("t2_div4", 32'(tr_div[t+4]), 32'd3);
    chk("t2_en9", 32'(tr_en[t+9]), 32'd1);
    chk("t2_en10", 32'(tr_en[t+10]), 32'd0);
    chk("t2_en13", 32'(tr_en[t+13]), 32'd1);
    chk("t2_en17", 32'(tr_en[t+17]), 32'd1);
    chk("t2_rdy13", 32'(tr_rdy[t+13]), 32'd0);
    chk("t2_rdy14", 32'(tr_rdy[t+14]), 32'd1);

    // 3: same-value request
    wait_ready();
    t = cyc; rv = 1; rd = 4'd3;
    step(1); rv = 0;
    step(8);
    for (int k = 1; k <= 6; k++) begin
      chk("t3_rdy", 32'(tr_rdy[t+k]), 32'd1);
      chk("t3_rst", 32'(tr_rst[t+k]), 32'd0);
    end

    // 4: back-to-back, req_div changes mid-sequence
    wait_ready();
    t = cyc; rv = 1; rd = 4'd5;
    step(3); rd = 4'd7;
    step(12); rv = 0;
    step(20);
    chk("t4_div17", 32'(tr_div[t+17]), 32'd5);
    chk("t4_div18", 32'(tr_div[t+18]), 32'd7);
    chk("t4_rdy14", 32'(tr_rdy[t+14]), 32'd1);
    chk("t4_rdy15", 32'(tr_rdy[t+15]), 32'd0);
    chk("t4_rdy28", 32'(tr_rdy[t+28]), 32'd1);
    chk("t4_rdy29", 32'(tr_rdy[t+29]), 32'd1);
    chk("t4_rst29", 32'(tr_rst[t+29]), 32'd0);

    // 5: rst_i pulse at T+4 of a 1 -> 3 change
    wait_ready();
    rv = 1; rd = 4'd1;
    step(1); rv = 0;
    step(1);
    wait_ready();
    t = cyc; rv = 1; rd = 4'd3;
    step(1); rv = 0;
    step(3); rst = 1;
    step(1); rst = 0;
    step(12);
    chk("t5_div4", 32'(tr_div[t+4]), 32'd3);
    chk("t5_div5", 32'(tr_div[t+5]), 32'd1);
    chk("t5_rst5", 32'(tr_rst[t+5]), 32'd1);
    chk("t5_rdy12", 32'(tr_rdy[t+12]), 32'd0);
    chk("t5_rdy13", 32'(tr_rdy[t+13]), 32'd1);
    chk("t5_en6", 32'(tr_en[t+6]), 32'd1);
    chk("t5_en7", 32'(tr_en[t+7]), 32'd0);

    // 6: change to div 0
    wait_ready();
    t = cyc; rv = 1; rd = 4'd0;
    step(1); rv = 0;
    step(16);
    chk("t6_en5", 32'(tr_en[t+5]), 32'd0);
    for (int k = 6; k <= 14; k++) chk("t6_en_every", 32'(tr_en[t+k]), 32'd1);

    // Randomized traffic; the per-cycle model check covers it.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (rv) begin
        if ($urandom_range(0, 9) == 0) rv = 0;
      end else begin
        rv = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 3) == 0)
        rd = ($urandom_range(0, 1) == 0) ? DIV_W'($urandom_range(0, 3))
                                         : DIV_W'($urandom_range(0, 15));
      step(1);
    end
    rst = 0; rv = 0;
    step(3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
